// File: rtl/mdu_pipelined_if.sv
// rtl/mdu_pipelined_if.sv - issue/result bundle between E-stage control and the MDU
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mdout;

  modport master (
    output start, op, rs, rt, cancel,
    input  busy, hi, lo, mdout
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output busy, hi, lo, mdout
  );
endinterface

// File: rtl/mdu_pipelined.sv
// rtl/mdu_pipelined.sv - multi-cycle multiply/divide unit with HI/LO accumulator and abort
module mdu_pipelined #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   hi_q, lo_q, sh_hi, sh_lo;

  logic               is_mul, is_div, sgn, load, commit, wr_hi, wr_lo, issue;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res, div_res, res_n;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, q_val, r_val;

  always_comb begin
    is_mul = bus.op inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11};
    is_div = bus.op inside {4'd2, 4'd3};
    sgn    = bus.op inside {4'd0, 4'd2, 4'd8, 4'd10};
    issue  = (state == IDLE) && bus.start && !bus.cancel;
  end

  // Product is formed at full 2*WIDTH so MADD/MSUB wrap modulo 2^(2*WIDTH).
  always_comb begin
    a_ext = sgn ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} : {{WIDTH{1'b0}}, bus.rs};
    b_ext = sgn ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt} : {{WIDTH{1'b0}}, bus.rt};
    prod  = a_ext * b_ext;
    case (bus.op)
      4'd8, 4'd9:   mul_res = {hi_q, lo_q} + prod;
      4'd10, 4'd11: mul_res = {hi_q, lo_q} - prod;
      default:      mul_res = prod;
    endcase
  end

  // Sign-magnitude divide; MIN_NEG / -1 falls out as MIN_NEG with remainder 0.
  always_comb begin
    a_neg  = sgn && bus.rs[WIDTH-1];
    b_neg  = sgn && bus.rt[WIDTH-1];
    a_mag  = a_neg ? -bus.rs : bus.rs;
    b_mag  = b_neg ? -bus.rt : bus.rt;
    b_safe = (bus.rt == '0) ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    q_val  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_val  = a_neg ? -r_mag : r_mag;
    if (bus.rt == '0) div_res = {bus.rs, {WIDTH{1'b1}}};
    else              div_res = {r_val, q_val};
    res_n = is_div ? div_res : mul_res;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (issue && (is_mul || is_div)) begin
          load    = 1'b1;
          state_n = RUN;
          cnt_n   = is_div ? DIV_LAT : MUL_LAT;
        end
        wr_hi = issue && (bus.op == 4'd4);
        wr_lo = issue && (bus.op == 4'd5);
      end
      RUN: begin
        if (bus.cancel) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
          commit  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      sh_hi <= '0;
      sh_lo <= '0;
    end else begin
      if (load) {sh_hi, sh_lo} <= res_n;
      if (commit) begin
        hi_q <= sh_hi;
        lo_q <= sh_lo;
      end else begin
        if (wr_hi) hi_q <= bus.rs;
        if (wr_lo) lo_q <= bus.rs;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    case (bus.op)
      4'd6:    bus.mdout = hi_q;
      4'd7:    bus.mdout = lo_q;
      default: bus.mdout = '0;
    endcase
  end
endmodule
